// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle core: opcodes, datapath select
// codes, ALU operations, controller states and decoded instruction classes.
package core_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_ARITH_I = 7'b0010011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    // Immediate extender format select.
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Next-PC source.
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    // Register-file write-back source.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // ALU operand A source.
    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    // ALU operation {sub/sra bit, funct3}.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE, CL_R, CL_ARITH_I, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
    } instr_class_t;

    // Branch compares: equality via SUB, signed via SLT, unsigned via SLTU.
    function automatic logic [3:0] branch_alu_op(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            3'd0, 3'd1: op = ALU_SUB;
            3'd4, 3'd5: op = ALU_SLT;
            default:    op = ALU_SLTU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct3 -> class, illegal flag
// and immediate format.
module multicycle_ctrl_decode
    import core_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t cls,
    output logic         illegal,
    output logic [2:0]   imm_sel
);

    // Classify the opcode and flag reserved funct3 encodings.
    always_comb begin
        cls     = CL_NONE;
        illegal = 1'b0;
        imm_sel = IMM_NONE;
        case (opcode)
            OP_R: cls = CL_R;
            OP_ARITH_I: begin
                cls     = CL_ARITH_I;
                imm_sel = IMM_I;
            end
            OP_LOAD: begin
                cls     = CL_LOAD;
                imm_sel = IMM_I;
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                cls     = CL_STORE;
                imm_sel = IMM_S;
                illegal = (funct3 > 3'd2);
            end
            OP_BRANCH: begin
                cls     = CL_BRANCH;
                imm_sel = IMM_B;
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OP_JAL: begin
                cls     = CL_JAL;
                imm_sel = IMM_J;
            end
            OP_JALR: begin
                cls     = CL_JALR;
                imm_sel = IMM_I;
                illegal = (funct3 != 3'd0);
            end
            OP_LUI: begin
                cls     = CL_LUI;
                imm_sel = IMM_U;
            end
            OP_AUIPC: begin
                cls     = CL_AUIPC;
                imm_sel = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared
// variable-latency memory port guarded by a watchdog counter.
// Memory handshake: mem_req is held high with stable address selects until
// the cycle mem_ready is seen high; that cycle completes the transfer. Only
// reset may withdraw a request.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_fetch,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [3:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);

    state_t       state;
    state_t       state_next;
    logic [CNT_W-1:0] wait_cnt;
    instr_class_t cls;
    logic         illegal;
    logic [2:0]   dec_imm;
    logic         waiting;
    logic         timeout;

    multicycle_ctrl_decode u_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .cls     (cls),
        .illegal (illegal),
        .imm_sel (dec_imm)
    );

    assign waiting   = (state == ST_FETCH) || (state == ST_MEM);
    assign timeout   = waiting && !mem_ready && (wait_cnt == TIMEOUT_CNT);
    assign state_dbg = state;

    // State, watchdog counter and sticky trap status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 1'b0;
        end else begin
            state <= state_next;
            if (waiting && !mem_ready && (state_next == state))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if ((state_next == ST_TRAP) && (state != ST_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= timeout;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_RST:    state_next = ST_FETCH;
            ST_FETCH: begin
                if (timeout)        state_next = ST_TRAP;
                else if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: state_next = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    CL_LOAD, CL_STORE: state_next = ST_MEM;
                    CL_BRANCH:         state_next = ST_FETCH;
                    default:           state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (timeout)        state_next = ST_TRAP;
                else if (mem_ready) state_next = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_RST;
        endcase
    end

    // Datapath controls; ALU selects are held through EXEC, MEM and WB.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        imm_sel      = IMM_NONE;
        alu_a_sel    = A_RS1;
        alu_b_sel    = 1'b0;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        retire       = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            ST_DECODE: imm_sel = dec_imm;
            ST_EXEC, ST_MEM, ST_WB: begin
                imm_sel = dec_imm;
                case (cls)
                    CL_R:       alu_op = {funct7_5, funct3};
                    CL_ARITH_I: begin
                        alu_b_sel = 1'b1;
                        alu_op    = {(funct3 == 3'd5) && funct7_5, funct3};
                    end
                    CL_LOAD, CL_STORE, CL_JALR: alu_b_sel = 1'b1;
                    CL_BRANCH:  alu_op = branch_alu_op(funct3);
                    CL_AUIPC: begin
                        alu_a_sel = A_PC;
                        alu_b_sel = 1'b1;
                    end
                    CL_LUI: begin
                        alu_a_sel = A_ZERO;
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase
                if (state == ST_EXEC) begin
                    case (cls)
                        CL_BRANCH: begin
                            retire = 1'b1;
                            if (br_taken) begin
                                pc_we  = 1'b1;
                                pc_sel = PC_REL;
                            end
                        end
                        CL_JAL: begin
                            pc_we  = 1'b1;
                            pc_sel = PC_REL;
                        end
                        CL_JALR: begin
                            pc_we  = 1'b1;
                            pc_sel = PC_ALU;
                        end
                        default: ;
                    endcase
                end else if (state == ST_MEM) begin
                    mem_req = 1'b1;
                    mem_we  = (cls == CL_STORE);
                    retire  = mem_ready && (cls == CL_STORE);
                end else begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                    if (cls == CL_LOAD)                          wb_sel = WB_MEM;
                    else if ((cls == CL_JAL) || (cls == CL_JALR)) wb_sel = WB_PC4;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a driver plays instructions and a memory with
// chosen latencies; a monitor summarises each instruction and compares it to
// a record predicted from the ISA-level rules.
module tb_multicycle_ctrl;

    localparam int T = 4;

    logic       clk, rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, br_taken, mem_ready;
    logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       retire, trap, trap_cause;
    logic [2:0] state_dbg;

    multicycle_ctrl #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .trap(trap),
        .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] n_cyc;
        logic [15:0] n_req;
        logic [15:0] n_mwe;
        logic [3:0]  n_fpw;
        logic [3:0]  n_rwe;
        logic [1:0]  wb_sel;
        logic [3:0]  n_pcw;
        logic [1:0]  pc_sel;
        logic        is_trap;
        logic        cause;
        logic        alu_care;
        logic [2:0]  imm_ex;
        logic [1:0]  a_ex;
        logic        b_ex;
        logic [3:0]  op_ex;
        logic        lui;
        logic [1:0]  wb_a;
    } rec_t;

    rec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction-level reference: latency and visible effects from the ISA rules.
    function automatic rec_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic bt, input int fd, input int md);
        rec_t r;
        string k;
        bit bad;
        int fw, mw;
        r = '0;
        case (op)
            7'h33: k = "R";     7'h13: k = "I";    7'h03: k = "LD";
            7'h23: k = "ST";    7'h63: k = "BR";   7'h6f: k = "JAL";
            7'h67: k = "JALR";  7'h37: k = "LUI";  7'h17: k = "AUIPC";
            default: k = "BAD";
        endcase
        bad = (k == "BAD") || (k == "LD" && (f3 == 3 || f3 == 6 || f3 == 7)) ||
              (k == "ST" && f3 > 2) || (k == "BR" && (f3 == 2 || f3 == 3)) ||
              (k == "JALR" && f3 != 0);
        fw = (fd > T) ? T : fd;
        r.n_cyc = 16'(fw + 1);
        r.n_req = 16'(fw + 1);
        if (fd > T) begin r.is_trap = 1; r.cause = 1; return r; end
        r.n_fpw = 1;
        r.n_cyc += 1;
        if (bad) begin r.is_trap = 1; r.cause = 0; return r; end
        r.n_cyc += 1;
        if (k == "LD" || k == "I" || k == "JALR") r.imm_ex = 1;
        else if (k == "ST")                       r.imm_ex = 2;
        else if (k == "BR")                       r.imm_ex = 3;
        else if (k == "LUI" || k == "AUIPC")      r.imm_ex = 4;
        else if (k == "JAL")                      r.imm_ex = 5;
        r.alu_care = !(k == "JAL" || k == "LUI");
        r.a_ex = (k == "AUIPC") ? 2'd1 : 2'd0;
        r.b_ex = !(k == "R" || k == "BR");
        if (k == "R")       r.op_ex = {f7, f3};
        else if (k == "I")  r.op_ex = {(f3 == 5) && f7, f3};
        else if (k == "BR") r.op_ex = (f3 < 2) ? 4'd8 : ((f3 < 6) ? 4'd2 : 4'd3);
        if ((k == "BR" && bt) || k == "JAL") begin r.n_pcw = 1; r.pc_sel = 1; end
        if (k == "JALR") begin r.n_pcw = 1; r.pc_sel = 2; end
        if (k == "BR") return r;
        if (k == "LD" || k == "ST") begin
            mw = (md > T) ? T : md;
            r.n_cyc += 16'(mw + 1);
            r.n_req += 16'(mw + 1);
            if (k == "ST") r.n_mwe = 16'(mw + 1);
            if (md > T) begin r.is_trap = 1; r.cause = 1; return r; end
            if (k == "ST") return r;
        end
        r.n_cyc += 1;
        r.n_rwe = 1;
        r.wb_sel = (k == "LD") ? 2'd1 : ((k == "JAL" || k == "JALR") ? 2'd2 : 2'd0);
        r.lui = (k == "LUI");
        r.wb_a = 2'd2;
        return r;
    endfunction

    task automatic end_event(input rec_t ob);
        rec_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_end", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk("cycles", ob.n_cyc, e.n_cyc);
        chk("mem_req_cycles", ob.n_req, e.n_req);
        chk("mem_we_cycles", ob.n_mwe, e.n_mwe);
        chk("fetch_pc_we", ob.n_fpw, e.n_fpw);
        chk("reg_we_count", ob.n_rwe, e.n_rwe);
        if (e.n_rwe != 0) chk("wb_sel", ob.wb_sel, e.wb_sel);
        chk("exec_pc_we", ob.n_pcw, e.n_pcw);
        if (e.n_pcw != 0) chk("pc_sel", ob.pc_sel, e.pc_sel);
        chk("trap", ob.is_trap, e.is_trap);
        chk("trap_cause", ob.cause, e.cause);
        chk("imm_sel_exec", ob.imm_ex, e.imm_ex);
        if (e.alu_care) begin
            chk("alu_a_exec", ob.a_ex, e.a_ex);
            chk("alu_b_exec", ob.b_ex, e.b_ex);
            chk("alu_op_exec", ob.op_ex, e.op_ex);
        end
        if (e.lui) chk("lui_wb_alu_a", ob.wb_a, e.wb_a);
    endtask

    // Monitor: summarise each instruction, compare at retire or trap entry.
    initial begin
        rec_t ob;
        bit   trap_seen;
        ob = '0;
        trap_seen = 0;
        forever begin
            @(negedge clk);
            if (state_dbg == 3'd0 || state_dbg == 3'd6) begin
                chk("idle_outputs_zero",
                    int'({mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, imm_sel,
                          alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel, retire}), 0);
                if (state_dbg == 3'd0) begin
                    ob = '0;
                    trap_seen = 0;
                end else if (!trap_seen) begin
                    trap_seen = 1;
                    ob.is_trap = trap;
                    ob.cause = trap_cause;
                    end_event(ob);
                    ob = '0;
                end
            end else begin
                ob.n_cyc += 1;
                if (mem_req) ob.n_req += 1;
                if (mem_we) ob.n_mwe += 1;
                if (pc_we && mem_is_fetch && pc_sel == 2'd0 && ir_we) ob.n_fpw += 1;
                if (pc_we && !mem_is_fetch) begin ob.n_pcw += 1; ob.pc_sel = pc_sel; end
                if (reg_we) begin ob.n_rwe += 1; ob.wb_sel = wb_sel; ob.wb_a = alu_a_sel; end
                if (state_dbg == 3'd3) begin
                    ob.imm_ex = imm_sel; ob.a_ex = alu_a_sel;
                    ob.b_ex = alu_b_sel; ob.op_ex = alu_op;
                end
                if (retire) begin
                    ob.is_trap = trap;
                    ob.cause = trap_cause;
                    end_event(ob);
                    ob = '0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Leaves the DUT in FETCH, #1 after a clock edge.
    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called #1 after an edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic bt, input int fd, input int md, input bit abort);
        int  w = 0;
        int  n = 0;
        bit  done = 0;
        bit  trapped = 0;
        opcode = op; funct3 = f3; funct7_5 = f7; br_taken = bt;
        if (!abort) exp_q.push_back(model(op, f3, f7, bt, fd, md));
        while (!done && n < 300) begin
            if (abort && mem_req && !mem_is_fetch) begin
                chk("abort_pre_mem_we", mem_we, 1);
                rst_n = 1'b0;
                #1;
                chk("abort_mem_req", mem_req, 0);
                chk("abort_mem_we", mem_we, 0);
                chk("abort_state", state_dbg, 0);
                chk("abort_trap", trap, 0);
                chk("abort_retire", retire, 0);
                mem_ready = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (mem_req) begin
                mem_ready = (w == (mem_is_fetch ? fd : md));
                w = mem_ready ? 0 : w + 1;
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            if (retire || state_dbg == 3'd6) begin
                done = 1;
                trapped = (state_dbg == 3'd6);
            end
            @(posedge clk); #1;
            n++;
        end
        mem_ready = 1'b0;
        if (!done) begin
            chk("instr_cycle_budget", n, -1);
            do_reset();
        end else if (trapped) begin
            repeat (3) @(posedge clk);
            #1;
            chk("trap_held", int'(trap), 1);
            do_reset();
        end
    endtask

    function automatic int rand_dly();
        return ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 1) : $urandom_range(0, 3);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ops[9];
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        rst_n = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        br_taken = 1'b0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", state_dbg, 0);
        chk("reset_trap", trap, 0);
        chk("reset_trap_cause", trap_cause, 0);
        chk("reset_mem_req", mem_req, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(7'h13, 3'd0, 1'b0, 1'b0, 0, 0, 0);  // ADDI x1,x0,5
        run_instr(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, 0);  // BEQ taken
        run_instr(7'h63, 3'd0, 1'b0, 1'b0, 0, 0, 0);  // BEQ not taken
        run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 3, 0);  // LW, slow memory
        run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, 0, 0);  // SW
        run_instr(7'h7f, 3'd0, 1'b0, 1'b0, 0, 0, 0);  // unknown opcode
        run_instr(7'h03, 3'd7, 1'b0, 1'b0, 0, 0, 0);  // load funct3=7
        run_instr(7'h13, 3'd0, 1'b0, 1'b0, T + 1, 0, 0); // fetch timeout
        run_instr(7'h13, 3'd0, 1'b0, 1'b0, T, 0, 0);     // ready at the limit
        run_instr(7'h23, 3'd2, 1'b0, 1'b0, T + 1 - 1, T + 1, 0); // store MEM timeout
        run_instr(7'h33, 3'd5, 1'b1, 1'b0, 1, 0, 0);  // SRA
        run_instr(7'h37, 3'd0, 1'b0, 1'b0, 0, 0, 0);  // LUI
        run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, 2, 1);  // store aborted by reset
        run_instr(7'h23, 3'd2, 1'b0, 1'b0, 0, 0, 0);  // clean re-fetch

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                op = 7'($urandom);
                while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 ||
                       op == 7'h6f || op == 7'h67 || op == 7'h37 || op == 7'h17)
                    op = 7'($urandom);
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (op == 7'h03 && (f3 == 3 || f3 == 6 || f3 == 7)) f3 = 3'd2;
                if (op == 7'h23) f3 = 3'(f3 % 3);
                if (op == 7'h63 && (f3 == 2 || f3 == 3)) f3 = f3 + 3'd2;
                if (op == 7'h67) f3 = 3'd0;
            end
            run_instr(op, f3, 1'($urandom), 1'($urandom), rand_dly(), rand_dly(), 0);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core datapath (PC, IR, register file, immediate extender, ALU, shared instruction/data memory port). It decodes the latched IR opcode/funct fields and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Each state drives the immediate-type select, ALU operand and opcode selects, and the PC, IR, register-file and memory enables. The single memory port uses a variable-latency req/ready handshake with a watchdog.

Parameters:
TIMEOUT_CYC, 255, max cycles a memory request may wait for mem_ready before trapping (1..65535)
CNT_W, 16, width of the wait counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
br_taken  in  1  datapath comparator result for the current ALU compare
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  store (1) or read (0)
mem_is_fetch  out  1  address mux selects PC (1) or ALU result (0)
ir_we  out  1  latch IR and old_pc
pc_we  out  1  PC write enable
pc_sel  out  2  0 PC+4, 1 old_pc+imm, 2 ALU result & ~1
imm_sel  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
alu_a_sel  out  2  0 rs1, 1 old_pc, 2 zero
alu_b_sel  out  1  0 rs2, 1 imm
alu_op  out  4  {sub/sra bit, funct3}; 4'b0000 = ADD
reg_we  out  1  register-file write
wb_sel  out  2  0 ALU, 1 mem data, 2 old_pc+4
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky: illegal instruction or timeout
trap_cause  out  1  0 illegal, 1 timeout
state_dbg  out  3  current state encoding

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. rst_n low -> RST asynchronously, wait counter 0, trap 0, trap_cause 0.
- All outputs are 0 in RST and TRAP.
- RST always goes to FETCH next cycle. TRAP is left only by reset.
- FETCH: mem_req=1, mem_is_fetch=1.
  - Hold until mem_ready.
  - On mem_ready, in the same cycle: ir_we=1, pc_we=1 with pc_sel=0, then go to DECODE.
- DECODE (1 cycle): classify the opcode.
  - Illegal cases: unknown opcode; load funct3 in {3,6,7}; store funct3>2; branch funct3 in {2,3}; JALR funct3!=0.
  - Illegal -> TRAP with trap_cause=0. Otherwise -> EXEC.
- imm_sel is combinational from opcode in DECODE/EXEC/MEM/WB: I for load/arith-imm/JALR, S, B, U for LUI/AUIPC, J for JAL, 0 for R-type. It is 0 in other states.
- EXEC, per instruction class:
  - R: a=rs1, b=rs2, alu_op={funct7_5,funct3} -> WB.
  - I-arith: b=imm; alu_op={funct3==5 ? funct7_5 : 0, funct3} -> WB.
  - Load/store: a=rs1, b=imm, ADD -> MEM.
  - Branch: a=rs1, b=rs2. alu_op is SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU. If br_taken, pc_we=1 with pc_sel=1. Then retire and go to FETCH.
  - JAL: pc_we=1, pc_sel=1 -> WB.
  - JALR: a=rs1, b=imm, ADD, pc_we=1, pc_sel=2 -> WB.
  - LUI: -> WB. AUIPC: a=old_pc, b=imm, ADD -> WB.
- MEM: mem_req=1, mem_we=1 for store, mem_is_fetch=0, ALU selects held from EXEC.
  - On mem_ready: load -> WB; store -> retire and go to FETCH.
- WB (1 cycle): reg_we=1, retire=1, then FETCH.
  - wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - LUI uses alu_a_sel=2, b=imm, ADD.
- Watchdog:
  - The wait counter increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0. It clears on mem_ready or on a state change.
  - When the count reaches TIMEOUT_CYC and mem_ready is still 0 -> TRAP with trap_cause=1.
  - If mem_ready arrives in the same cycle as the count reaching TIMEOUT_CYC, the handshake completes and no trap is raised.
- mem_req stays asserted and address selects stay stable until mem_ready. The requester never withdraws a request.
- rst_n asserted mid-request drops mem_req immediately (combinationally from the state register). The memory must tolerate an aborted request.
- Latency per instruction, assuming 1-cycle memory: branch 3, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (R, LOAD, ARITH_I, JALR, LUI, AUIPC, STORE, BRANCH, JAL);
  - imm_sel, pc_sel, wb_sel and alu_op encodings;
  - the state enum.
- The immediate extender consumes the same imm_sel constants.
- One sub-module, multicycle_ctrl_decode: purely combinational. It maps opcode/funct3 to instruction class, illegal flag and imm_sel. The FSM and watchdog stay in the top module.

Test Plan:
- Reset release, ADDI x1,x0,5 (0x00500093), mem_ready=1 every cycle -> RST,FETCH,DECODE,EXEC,WB. imm_sel=1, alu_b_sel=1, reg_we in cycle 4, retire once.
- BEQ taken (0x00000463) with br_taken=1 -> imm_sel=3, pc_we with pc_sel=1 in EXEC, no reg_we, retire in cycle 3. With br_taken=0: no pc_we in EXEC.
- LW (0x0000A103) with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB with wb_sel=1. SW (0x0020A023) -> mem_we=1, no WB.
- Opcode 7'b1111111, and load with funct3=7 -> TRAP from DECODE, trap=1, trap_cause=0. All enables 0 until rst_n low.
- TIMEOUT_CYC=4 with mem_ready held low in FETCH -> TRAP after the count reaches 4, trap_cause=1. Repeat with mem_ready at that same cycle -> DECODE, no trap.
- rst_n low for 1 cycle during MEM of a store -> mem_req and mem_we drop asynchronously, state=RST, trap=0, no retire. Next instruction is re-fetched cleanly.
